// File: rtl/conv_window_buffer.sv
// Sliding-window stage feeding the 1D convolution: shifts signed samples into an
// N-deep window and emits it every STRIDE accepts. Define CONV_WIN_PAD_EN for causal zero-padding.

module conv_window_slot #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)        q <= '0;
    else if (shift_en) q <= clr ? '0 : d;
  end
endmodule

module conv_window_buffer #(
  parameter int IN_WIDTH = 12,
  parameter int N        = 5,
  parameter int STRIDE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [N*IN_WIDTH-1:0] x_out,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);
  localparam int FILL_W = $clog2(N + 1);
  localparam int SC_W   = $clog2(STRIDE) + 1;

  typedef enum logic {FILL, RUN} state_t;

`ifdef CONV_WIN_PAD_EN
  // Start the stride phase at its wrap point so the first sample of a frame emits.
  localparam state_t          START_ST = RUN;
  localparam logic [SC_W-1:0] SC_START = SC_W'(STRIDE - 1);
`else
  localparam state_t          START_ST = FILL;
  localparam logic [SC_W-1:0] SC_START = '0;
`endif

  state_t                         state;
  logic [FILL_W-1:0]              fill_cnt;
  logic [SC_W-1:0]                stride_cnt;
  logic [N-1:0][IN_WIDTH-1:0]     slot_q;
  logic [N-1:0][IN_WIDTH-1:0]     slot_d;
  logic                           accept;
  logic                           sc_wrap;
  logic                           emit;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign sc_wrap  = (stride_cnt == SC_W'(STRIDE - 1));
  assign slot_d   = {slot_q[N-2:0], in_data};

  always_comb begin
    emit = 1'b0;
    if (accept)
      emit = (state == FILL) ? (fill_cnt == FILL_W'(N - 1)) : sc_wrap;
  end

  // Frame end clears every slot on the same accept that would shift it.
  generate
    for (genvar l = 0; l < N; l++) begin : g_slot
      conv_window_slot #(.W(IN_WIDTH)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .clr      (in_last),
        .d        (slot_d[l]),
        .q        (slot_q[l])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= START_ST;
      fill_cnt   <= '0;
      stride_cnt <= SC_START;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      x_out      <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (emit) begin
        x_out     <= slot_d;
        out_valid <= 1'b1;
        out_last  <= in_last;
      end
      if (accept) begin
        if (in_last) begin
          state      <= START_ST;
          fill_cnt   <= '0;
          stride_cnt <= SC_START;
        end else if (state == FILL) begin
          fill_cnt <= fill_cnt + 1'b1;
          if (emit) begin
            state      <= RUN;
            stride_cnt <= '0;
          end
        end else begin
          stride_cnt <= sc_wrap ? '0 : stride_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench: two buffers (STRIDE 1 and 2) share one input stream; a frame-indexed
// reference model predicts every window and a negedge monitor checks what comes out.

module tb_conv_window_buffer;
  localparam int W = 12;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready  [2];
  logic [N*W-1:0] x_out     [2];
  logic           out_valid [2];
  logic           out_last  [2];
  logic           out_ready [2];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      conv_window_buffer #(.IN_WIDTH(W), .N(N), .STRIDE(g + 1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready[g]),
        .x_out     (x_out[g]),
        .out_valid (out_valid[g]),
        .out_last  (out_last[g]),
        .out_ready (out_ready[g])
      );
    end
  endgenerate

  typedef struct {
    int             inst;
    logic [N*W-1:0] x;
    logic           last;
  } exp_t;

  exp_t           sb [$];
  int             n_chk = 0;
  int             n_pass = 0;
  logic [W-1:0]   hist [2][64];
  int             fidx [2];
  logic [N*W-1:0] hold_x [2];
  bit             hold_v [2];
  bit             rst_d = 1'b1;
  bit             done = 1'b0;
  bit             checked_end = 1'b0;

  task automatic chk(input string name, input int g, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %h expected %h", name, g, act, exp);
  endtask

  // Window at frame index i: slot l holds the sample i-l, zero before frame start.
  function automatic logic [N*W-1:0] model_window(input int g, input int i);
    logic [N*W-1:0] w;
    w = '0;
    for (int l = 0; l < N; l++)
      if (i - l >= 0) w[l*W +: W] = hist[g][(i - l) % 64];
    return w;
  endfunction

  function automatic bit model_emit(input int s, input int i);
`ifdef CONV_WIN_PAD_EN
    return (i % s) == 0;
`else
    return (i >= N - 1) && (((i - (N - 1)) % s) == 0);
`endif
  endfunction

  initial begin
    fidx[0] = 0; fidx[1] = 0;
    hold_v[0] = 1'b0; hold_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!rst_d) begin
          chk("rst_valid", g, N*W'(out_valid[g]), '0);
          chk("rst_last", g, N*W'(out_last[g]), '0);
          chk("rst_x", g, x_out[g], '0);
        end
        if (rst_n) begin
          if (out_valid[g] && out_ready[g]) begin
            int k;
            k = -1;
            foreach (sb[j]) if (k < 0 && sb[j].inst == g) k = j;
            if (k < 0) chk("unexpected_win", g, x_out[g], 'x);
            else begin
              chk("win", g, x_out[g], sb[k].x);
              chk("last", g, N*W'(out_last[g]), N*W'(sb[k].last));
              sb.delete(k);
            end
          end
          if (out_valid[g] && !out_ready[g]) begin
            chk("stall_rdy", g, N*W'(in_ready[g]), '0);
            if (hold_v[g]) chk("stall_x", g, x_out[g], hold_x[g]);
            hold_x[g] = x_out[g];
            hold_v[g] = 1'b1;
          end else hold_v[g] = 1'b0;
        end else hold_v[g] = 1'b0;
      end
      // Reference model: consume the accept that the coming edge will perform.
      for (int g = 0; g < 2; g++) begin
        if (!rst_n) begin
          fidx[g] = 0;
          for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].inst == g) sb.delete(j);
        end else if (in_valid && in_ready[g]) begin
          hist[g][fidx[g] % 64] = in_data;
          if (model_emit(g + 1, fidx[g]))
            sb.push_back('{inst: g, x: model_window(g, fidx[g]), last: in_last});
          fidx[g] = in_last ? 0 : fidx[g] + 1;
        end
      end
      if (done && !checked_end) begin
        for (int g = 0; g < 2; g++) begin
          int left;
          left = 0;
          foreach (sb[j]) if (sb[j].inst == g) left++;
          chk("drain", g, N*W'(left), '0);
        end
        checked_end = 1'b1;
      end
      rst_d = rst_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit l);
    in_valid = 1'b1;
    in_data  = W'(d);
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 1; i <= 9; i++) send(i, i == 9);
    repeat (2) tick();
    for (int i = 1; i <= 5; i++) send(i, i == 5);
    for (int i = 10; i <= 14; i++) send(i, i == 14);
    send(-2048, 1'b0); send(2047, 1'b0); send(-1, 1'b0); send(5, 1'b0); send(6, 1'b1);

    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    in_valid = 1'b1;
    in_data  = W'(6);
    repeat (10) tick();
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    tick();
    send(7, 1'b0);
    send(8, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = W'($urandom);
      in_last      = ($urandom_range(0, 15) == 0);
      out_ready[0] = ($urandom_range(0, 3) != 0);
      out_ready[1] = ($urandom_range(0, 3) != 0);
      rst_n        = (c != 1500);
      tick();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (5) tick();
    done = 1'b1;
    for (int t = 0; t < 10 && !checked_end; t++) tick();
    if (!checked_end) begin
      $display("FAIL end_check: drain check not reached, got 0 expected 1");
      $fatal(1, "end check timeout");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
Sliding-window stage directly upstream of the comb-only 1D convolution. Accepts a stream of signed samples and assembles N-sample windows, packed into the convolution's x_in format. Window emission is decimated by STRIDE. Valid/ready handshake on both sides; one registered output window.

Parameters:
IN_WIDTH, 12, sample width (signed two's complement)
N, 5, window length (kernel length); legal range 2..32
STRIDE, 1, samples advanced between emitted windows; legal range 1..N

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
in_data  in  IN_WIDTH  input sample
in_valid  in  1  in_data valid
in_last  in  1  qualifies the final sample of a frame
in_ready  out  1  stage can accept a sample this cycle
x_out  out  N*IN_WIDTH  packed window for conv x_in
out_valid  out  1  x_out holds an unconsumed window
out_last  out  1  window contains the frame's last sample
out_ready  in  1  downstream consumes the window this cycle

Behaviour:
- One clock; rst_n is synchronous, active-low. Reset is sampled on the clk rising edge only.
- Reset values: out_valid=0, out_last=0, x_out=0, sample shift register=0, fill count=0, stride count=0, state=FILL.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput at 1 sample/cycle.
- Accept = in_valid && in_ready. On each accept, the shift register moves by one: slot 0 takes in_data, slot k takes slot k-1, and slot N-1 is discarded.
- Packing: x_out[l*IN_WIDTH +: IN_WIDTH] = slot l. Slot 0 is the newest sample and slot N-1 the oldest.
- State FILL: fill count increments per accept. The accept that brings the count to N emits the first window, sets stride count=0, and moves to RUN.
- State RUN: stride count increments per accept, modulo STRIDE. On every accept, the shift-register contents are computed for that cycle. A window is emitted on an accept that leaves stride count == STRIDE-1 before the increment; with STRIDE=1, every accept emits.
- Emit: on the next edge, x_out is loaded with the post-shift register contents, out_valid=1, and out_last=in_last.
- Latency: 1 cycle from the accepting edge to out_valid.
- out_valid clears on out_valid && out_ready unless a new emit occurs in the same cycle. In that case x_out reloads and out_valid stays 1.
- While out_valid && !out_ready: x_out and out_last hold stable, in_ready=0, and no shift occurs.
- Frame end (accept with in_last=1):
  - Emission follows the normal rule for that sample, evaluated before the reset below.
  - Then fill count=0, stride count=0, state=FILL, and the shift register is cleared to 0.
  - The next sample starts a new frame.
- in_last on a sample that leaves FILL incomplete: no window is emitted and out_last is not asserted. The partial frame is dropped; this is intended.
- Reset mid-operation: the pending window is lost, out_valid=0 the following cycle, and all counters are cleared.
- Width rules: samples pass unmodified, with no arithmetic. The fill counter is $clog2(N+1) bits and the stride counter is $clog2(STRIDE)+1 bits.

Optional Feature:
- Macro: CONV_WIN_PAD_EN.
- Defined: causal zero-padding.
  - FILL is skipped; state is RUN from reset and after every frame end.
  - The cleared shift register supplies N-1 leading zeros.
  - The first sample of each frame emits a window of {sample, 0, ..., 0}, then stride decimation applies.
  - Output length per frame = ceil(L/STRIDE) for a frame of L samples.
- Undefined: behaviour as above, with (L-N)/STRIDE+1 windows per frame when L>=N.

Test Plan:
- Reset, N=5, STRIDE=1, stream 1,2,3,4,5,6, out_ready=1 → first out_valid one cycle after sample 5, x_out slots {5,4,3,2,1}. Next window {6,5,4,3,2}. in_ready constantly 1.
- STRIDE=2, N=5, samples 1..9 → windows {5..1}, {7..3}, {9..5}. No window after samples 6 or 8.
- Backpressure: hold out_ready=0 after the first window → in_ready=0, x_out stable and no shift for 10 cycles. Releasing gives the next window on the following accepts with no sample loss.
- Frame boundary: samples 1..5 with in_last on 5, then 10..14 → window {5,4,3,2,1} with out_last=1. The next window is {14,13,12,11,10}, with no mixing of 5 and 10.
- Negative values: -2048 (0x800), 2047, -1 → packed bit-exact into x_out, no sign corruption.
- CONV_WIN_PAD_EN, N=5, STRIDE=1, samples 7,8 → windows {7,0,0,0,0}, {8,7,0,0,0}. After in_last, the next frame starts again with zeros. Mid-stream rst_n=0 for 1 cycle → out_valid=0 the next cycle.
